pipe_stage_regs: RTL and testbench

- Owns the three pipeline registers of the 8-bit core: IF/ID, ID/EX and EX/WB.
- Also owns the EX-stage ALU and the writeback port.
- Acts as the other end of the hazard/forwarding interface: publishes stage register fields to the forwarding unit, and consumes its per-stage flush requests and forward-select.
- Sits between fetch (valid/ready handshake) and the register file (async read, sync write).

---
 rtl/pipe_stage_regs_pkg.sv | 30 +++
 rtl/pipe_stage_regs_if.sv | 12 +
 rtl/pipe_alu.sv | 25 ++
 rtl/pipe_stage_regs.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_regs.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the pipeline stage registers: opcodes, instruction
// field positions and default widths.
package pipe_stage_regs_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefRegAw = 3;
  localparam int unsigned DefCntW  = 16;
  localparam int unsigned InstrW   = 8;

  // Instruction layout: [7:6] opcode, [5:3] rd, [2:0] rs.
  localparam int unsigned OpcMsb = 7;
  localparam int unsigned OpcLsb = 6;
  localparam int unsigned RdMsb  = 5;
  localparam int unsigned RdLsb  = 3;
  localparam int unsigned RsMsb  = 2;
  localparam int unsigned RsLsb  = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } opcode_e;

  // Number of asserted flush requests in one cycle (0..3).
  function automatic logic [1:0] flush_popcount(logic a, logic b, logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Fetch-side valid/ready instruction handshake.
interface pipe_stage_regs_if;
  import pipe_stage_regs_pkg::*;

  logic              in_valid;
  logic [InstrW-1:0] in_instr;
  logic              in_ready;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);

endinterface

// File: rtl/pipe_alu.sv
// Combinational EX-stage ALU; results wrap modulo 2^DATA_W.
module pipe_alu
  import pipe_stage_regs_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  opcode_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  // Decode opcode into the selected operation.
  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/WB pipeline registers with EX ALU and writeback port.
// Optional bubble counter enabled by defining PIPE_FLUSH_COUNT_EN.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned REG_AW = DefRegAw,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_regs_if.slave  fetch_io,
  output logic [REG_AW-1:0] rf_addr_a,
  output logic [REG_AW-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              if_id_flush,
  input  logic              id_ex_flush,
  input  logic              ex_wb_flush,
  input  logic              alu_fwd,
  output logic [1:0]        ex_opcode,
  output logic [REG_AW-1:0] id_ex_src_reg,
  output logic [REG_AW-1:0] id_ex_dest_reg,
  output logic [REG_AW-1:0] ex_wb_reg,
  output logic              ex_wb_valid,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  flush_count
);

  logic              ifid_valid_q, ifid_valid_d;
  logic [InstrW-1:0] ifid_instr_q, ifid_instr_d;

  logic              idex_valid_q, idex_valid_d;
  opcode_e           idex_op_q, idex_op_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
  logic [REG_AW-1:0] idex_rs_q, idex_rs_d;
  logic [DATA_W-1:0] idex_a_q, idex_a_d;
  logic [DATA_W-1:0] idex_b_q, idex_b_d;

  logic              exwb_valid_q, exwb_valid_d;
  logic [REG_AW-1:0] exwb_rd_q, exwb_rd_d;
  logic [DATA_W-1:0] exwb_res_q, exwb_res_d;

  logic              byp_a, byp_b;
  logic [DATA_W-1:0] alu_a, alu_res;

  // A stall or IF/ID flush leaves the fetched instruction to be replayed.
  assign fetch_io.in_ready = reset & ~if_id_flush & ~id_ex_flush;

  assign rf_addr_a = ifid_instr_q[RdMsb:RdLsb];
  assign rf_addr_b = ifid_instr_q[RsMsb:RsLsb];

  // Regfile writes land at the edge the ID/EX operands are captured.
  assign byp_a = wb_en && (wb_addr == rf_addr_a);
  assign byp_b = wb_en && (wb_addr == rf_addr_b);

  assign alu_a = alu_fwd ? exwb_res_q : idex_a_q;

  pipe_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i  (idex_op_q),
    .a_i   (alu_a),
    .b_i   (idex_b_q),
    .res_o (alu_res)
  );

  // Next-state for all three stage registers; each stage obeys its own flush.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    if (if_id_flush) begin
      ifid_valid_d = 1'b0;
    end else if (!id_ex_flush) begin
      ifid_valid_d = fetch_io.in_valid;
      ifid_instr_d = fetch_io.in_instr;
    end

    idex_valid_d = 1'b0;
    idex_op_d    = idex_op_q;
    idex_rd_d    = idex_rd_q;
    idex_rs_d    = idex_rs_q;
    idex_a_d     = idex_a_q;
    idex_b_d     = idex_b_q;
    if (!id_ex_flush) begin
      idex_valid_d = ifid_valid_q;
      idex_op_d    = opcode_e'(ifid_instr_q[OpcMsb:OpcLsb]);
      idex_rd_d    = rf_addr_a;
      idex_rs_d    = rf_addr_b;
      idex_a_d     = byp_a ? exwb_res_q : rf_data_a;
      idex_b_d     = byp_b ? exwb_res_q : rf_data_b;
    end

    exwb_valid_d = 1'b0;
    exwb_rd_d    = exwb_rd_q;
    exwb_res_d   = exwb_res_q;
    if (!ex_wb_flush) begin
      exwb_valid_d = idex_valid_q;
      exwb_rd_d    = idex_rd_q;
      exwb_res_d   = alu_res;
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      idex_valid_q <= 1'b0;
      idex_op_q    <= OP_ADD;
      idex_rd_q    <= '0;
      idex_rs_q    <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      exwb_valid_q <= 1'b0;
      exwb_rd_q    <= '0;
      exwb_res_q   <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      idex_valid_q <= idex_valid_d;
      idex_op_q    <= idex_op_d;
      idex_rd_q    <= idex_rd_d;
      idex_rs_q    <= idex_rs_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      exwb_valid_q <= exwb_valid_d;
      exwb_rd_q    <= exwb_rd_d;
      exwb_res_q   <= exwb_res_d;
    end
  end

  assign ex_opcode      = idex_op_q;
  assign id_ex_src_reg  = idex_rs_q;
  assign id_ex_dest_reg = idex_rd_q;
  assign ex_wb_reg      = exwb_rd_q;
  assign ex_wb_valid    = exwb_valid_q;
  assign wb_en          = exwb_valid_q;
  assign wb_addr        = exwb_rd_q;
  assign wb_data        = exwb_res_q;

`ifdef PIPE_FLUSH_COUNT_EN
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W:0]   flush_sum;

  // Saturating count of bubbles inserted across all stages.
  always_comb begin
    flush_sum   = {1'b0, flush_cnt_q} +
                  {{(CNT_W-1){1'b0}}, flush_popcount(if_id_flush, id_ex_flush, ex_wb_flush)};
    flush_cnt_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
  end

  // Bubble counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush_count = flush_cnt_q;
`else
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;

`ifdef PIPE_FLUSH_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  rf_addr_a, rf_addr_b;
  logic [7:0]  rf_data_a, rf_data_b;
  logic        if_id_flush, id_ex_flush, ex_wb_flush, alu_fwd;
  logic [1:0]  ex_opcode;
  logic [2:0]  id_ex_src_reg, id_ex_dest_reg, ex_wb_reg;
  logic        ex_wb_valid, wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [15:0] flush_count;

  logic [7:0]  rf [8];
  logic        poke_en;
  logic [2:0]  poke_addr;
  logic [7:0]  poke_data;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q [$];
  int          cnt_exp = 0;

  pipe_stage_regs_if fetch_if ();

  pipe_stage_regs dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_io       (fetch_if),
    .rf_addr_a      (rf_addr_a),
    .rf_addr_b      (rf_addr_b),
    .rf_data_a      (rf_data_a),
    .rf_data_b      (rf_data_b),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_wb_flush    (ex_wb_flush),
    .alu_fwd        (alu_fwd),
    .ex_opcode      (ex_opcode),
    .id_ex_src_reg  (id_ex_src_reg),
    .id_ex_dest_reg (id_ex_dest_reg),
    .ex_wb_reg      (ex_wb_reg),
    .ex_wb_valid    (ex_wb_valid),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: async read, sync write; bench pokes preload values.
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];
  always @(posedge clk) begin
    if (wb_en === 1'b1) rf[wb_addr] <= wb_data;
    if (poke_en) rf[poke_addr] <= poke_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [2:0] a, input logic [7:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    step();
    poke_en   = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Present one instruction; it is accepted at the next edge.
  task automatic issue(input logic [7:0] instr);
    fetch_if.in_valid = 1'b1;
    fetch_if.in_instr = instr;
    @(negedge clk);
    chk("in_ready_issue", {31'b0, fetch_if.in_ready}, 32'd1);
    step();
  endtask

  task automatic idle(input int n);
    fetch_if.in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Scoreboard monitor: every writeback must match the oldest expectation.
  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (wb_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got addr %0d data 0x%0h, required no writeback",
                   wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", {29'b0, wb_addr}, {29'b0, e[10:8]});
          chk("wb_data", {24'b0, wb_data}, {24'b0, e[7:0]});
        end
      end
    end
  endtask

  initial begin
    reset             = 1'b0;
    fetch_if.in_valid = 1'b0;
    fetch_if.in_instr = 8'h00;
    if_id_flush       = 1'b0;
    id_ex_flush       = 1'b0;
    ex_wb_flush       = 1'b0;
    alu_fwd           = 1'b0;
    poke_en           = 1'b0;
    poke_addr         = '0;
    poke_data         = '0;

    // Reset state; clear the regfile model while held in reset.
    for (int i = 0; i < 8; i++) poke(3'(i), 8'h00);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, fetch_if.in_ready}, 32'd0);
    chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst_ex_wb_valid", {31'b0, ex_wb_valid}, 32'd0);
    chk("rst_wb_data", {24'b0, wb_data}, 32'd0);
    chk("rst_flush_count", {16'b0, flush_count}, 32'd0);
    fork
      monitor();
    join_none
    step();
    reset = 1'b1;
    step();

    // 1: straight-line add r1,r3 = 5+7.
    poke(3'd1, 8'd5);
    poke(3'd3, 8'd7);
    push_exp(3'd1, 8'd12);
    issue(8'h0B);
    idle(6);

    // 2: add r1,r2 then sub r1,r3 with EX/WB forward and a stall+flush cycle.
    poke(3'd1, 8'd5);
    poke(3'd2, 8'd2);
    poke(3'd3, 8'd1);
    push_exp(3'd1, 8'd7);
    push_exp(3'd1, 8'd6);
    issue(8'h0A);
    issue(8'h4B);
    fetch_if.in_valid = 1'b0;
    step();
    alu_fwd           = 1'b1;
    if_id_flush       = 1'b1;
    id_ex_flush       = 1'b1;
    fetch_if.in_valid = 1'b1;
    fetch_if.in_instr = 8'h91;  // and r2,r1 must be replayed, not lost
    @(negedge clk);
    chk("flush_in_ready", {31'b0, fetch_if.in_ready}, 32'd0);
    step();
    alu_fwd     = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    push_exp(3'd2, 8'd2);  // 2 & 6
    @(negedge clk);
    chk("replay_in_ready", {31'b0, fetch_if.in_ready}, 32'd1);
    step();
    idle(6);

    // 3: add r2,r4 writes r2=9 while add r2,r2 sits in IF/ID -> both bypass.
    poke(3'd2, 8'd2);
    poke(3'd4, 8'd7);
    push_exp(3'd2, 8'd9);
    push_exp(3'd2, 8'd18);
    issue(8'h14);
    fetch_if.in_valid = 1'b0;
    step();
    issue(8'h12);
    idle(6);

    // 4: wraparound add/sub and an OR.
    poke(3'd0, 8'h00);
    poke(3'd1, 8'hFF);
    poke(3'd2, 8'h01);
    poke(3'd6, 8'hA0);
    poke(3'd7, 8'h05);
    push_exp(3'd1, 8'h00);
    push_exp(3'd0, 8'hFF);
    push_exp(3'd6, 8'hA5);
    issue(8'h0A);
    issue(8'h42);
    issue(8'hF7);
    idle(6);

    // 5: reset with three instructions in flight; only the oldest writes back.
    poke(3'd1, 8'd3);
    poke(3'd3, 8'd4);
    push_exp(3'd1, 8'd7);
    issue(8'h0B);
    issue(8'h4B);
    issue(8'h91);
    reset             = 1'b0;
    fetch_if.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, fetch_if.in_ready}, 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("midrst_ex_wb_valid", {31'b0, ex_wb_valid}, 32'd0);
    chk("midrst_wb_data", {24'b0, wb_data}, 32'd0);
    chk("midrst_wb_addr", {29'b0, wb_addr}, 32'd0);
    chk("midrst_ex_opcode", {30'b0, ex_opcode}, 32'd0);
    chk("midrst_id_ex_src", {29'b0, id_ex_src_reg}, 32'd0);
    chk("midrst_id_ex_dest", {29'b0, id_ex_dest_reg}, 32'd0);
    chk("midrst_rf_addr_a", {29'b0, rf_addr_a}, 32'd0);
    chk("midrst_flush_count", {16'b0, flush_count}, 32'd0);
    idle(6);

    // 6: all three flushes held; counter adds 3 per edge, saturating.
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    ex_wb_flush = 1'b1;
    @(negedge clk);
    chk("flush3_in_ready", {31'b0, fetch_if.in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (CntEn) cnt_exp = (cnt_exp > 65535 - 3) ? 65535 : cnt_exp + 3;
    end
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_wb_flush = 1'b0;
    @(negedge clk);
    chk("flush_count_5", {16'b0, flush_count}, CntEn ? 32'd15 : 32'd0);
    step();
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    ex_wb_flush = 1'b1;
    for (int i = 0; i < 21850; i++) begin
      step();
      if (CntEn) cnt_exp = (cnt_exp > 65535 - 3) ? 65535 : cnt_exp + 3;
    end
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_wb_flush = 1'b0;
    @(negedge clk);
    chk("flush_count_sat", {16'b0, flush_count}, cnt_exp);
    step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
